// File: rtl/somador_serial.sv
// somador_serial: bit-serial adder (optional subtractor).
//
// Loads two WIDTH-bit operands on an accepted start and processes them
// LSB-first, one bit per clock, through a single full-adder cell with a
// carry flip-flop. The result and carry-out appear together with a
// one-cycle done pulse.
//
// Optional feature macro: SUBTRACT_EN
//   When defined, the op input exists. op=1 selects A-B using a borrow
//   chain, and Cout then carries the final borrow. When the macro is not
//   defined, the unit is add-only and no subtract logic is built.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   A      in   WIDTH-bit augend/minuend, sampled on accepted start
//   B      in   WIDTH-bit addend/subtrahend, sampled on accepted start
//   op     in   0=add, 1=subtract (SUBTRACT_EN only)
//   busy   out  high while in RUN
//   done   out  one-cycle pulse when S/Cout update
//   S      out  WIDTH-bit registered result
//   Cout   out  registered carry-out / borrow-out

`timescale 1ns/1ps

module somador_serial #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SUBTRACT_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
`ifdef SUBTRACT_EN
    logic             r_op;
`endif

    logic             w_a;
    logic             w_b;
    logic             w_s;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    // Single full-adder cell; the sum bit is identical for add and subtract,
    // only the carry/borrow recurrence differs.
    always_comb begin
        w_a = r_sa[0];
        w_b = r_sb[0];
        w_s = w_a ^ w_b ^ r_carry;
`ifdef SUBTRACT_EN
        if (r_op) begin
            w_carry_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_carry);
        end else begin
            w_carry_next = (w_a & w_b) | (r_carry & (w_a ^ w_b));
        end
`else
        w_carry_next = (w_a & w_b) | (r_carry & (w_a ^ w_b));
`endif
        // Insert the new sum bit at the MSB; written as shifts so WIDTH=1 is legal.
        w_res_next = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
`ifdef SUBTRACT_EN
            r_op    <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa    <= A;
                        r_sb    <= B;
`ifdef SUBTRACT_EN
                        r_op    <= op;
`endif
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_res   <= w_res_next;
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_carry <= w_carry_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Publish the full result only once all bits are in.
                        r_s     <= w_res_next;
                        r_cout  <= w_carry_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign S    = r_s;
    assign Cout = r_cout;

endmodule
